imem_port0_arb: RTL and testbench

Two-requester arbiter and initializer for port 0 of the registered dual-port memory wrapper (imem2rwpx family). After reset it optionally sweeps the whole port-0 address space writing a fill value. It then shares port 0 between two requesters with round-robin arbitration and returns read data to the issuing requester using a fixed-latency tag pipeline. Port 1 of the memory is not touched by this block.

---
 rtl/imem_port0_arb_pkg.sv | 16 +
 rtl/imem_rd_tagpipe.sv | 29 ++
 rtl/imem_port0_arb.sv | 165 ++++++++++++++++
 tb/tb_imem_port0_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_port0_arb_pkg.sv
// Shared types for the imem port-0 arbiter: FSM states, requester id and read-tag entry.
package imem_port0_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_e;

   typedef logic req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
   } tag_ent_t;

endpackage

// File: rtl/imem_rd_tagpipe.sv
// Fixed-latency {vld, id} shift register that follows each issued read to its data return.
module imem_rd_tagpipe
   import imem_port0_arb_pkg::*;
#(
   parameter int RDLAT = 3
) (
   input  logic     clk0,
   input  logic     p0rst_,
   input  tag_ent_t tag_in,
   output tag_ent_t tag_out
);

   tag_ent_t [RDLAT-1:0] pipe_r;

   // shift tags toward the tail; reset discards every read still in flight
   always_ff @(posedge clk0 or negedge p0rst_) begin
      if (!p0rst_) begin
         pipe_r <= '0;
      end else begin
         pipe_r[0] <= tag_in;
         for (int i = 1; i < RDLAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign tag_out = pipe_r[RDLAT-1];

endmodule

// File: rtl/imem_port0_arb.sv
// Port-0 round-robin arbiter for the imem2rwpx wrapper with read-data return to the issuer.
// Define IMEM_ARB_INIT_EN to include the post-reset FILL sweep over addresses 0..DEPTH-1.
module imem_port0_arb
   import imem_port0_arb_pkg::*;
#(
   parameter int               ADDRBIT = 6,
   parameter int               DEPTH   = 48,
   parameter int               WIDTH   = 80,
   parameter int               RDLAT   = 3,
   parameter logic [WIDTH-1:0] FILL    = {WIDTH{1'b0}}
) (
   input  logic               clk0,
   input  logic               p0rst_,
   input  logic               req0,
   input  logic               rnw0,
   input  logic [ADDRBIT-1:0] addr0,
   input  logic [WIDTH-1:0]   wdat0,
   input  logic               req1,
   input  logic               rnw1,
   input  logic [ADDRBIT-1:0] addr1,
   input  logic [WIDTH-1:0]   wdat1,
   output logic               gnt0,
   output logic               gnt1,
   output logic               rdvld0,
   output logic               rdvld1,
   output logic [WIDTH-1:0]   rddat0,
   output logic [WIDTH-1:0]   rddat1,
   output logic [ADDRBIT-1:0] mem_a,
   output logic               mem_we,
   output logic               mem_re,
   output logic [WIDTH-1:0]   mem_di,
   input  logic [WIDTH-1:0]   mem_do,
   output logic               init_done
);

   localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

   logic               init_act_s;
   logic [ADDRBIT-1:0] init_a_s;
   req_id_t            rr_ptr_r, rr_nxt_s;
   logic               gnt0_s, gnt1_s, we_s, re_s;
   logic [ADDRBIT-1:0] a_s, mem_a_r;
   logic [WIDTH-1:0]   di_s, mem_di_r;
   tag_ent_t           tag_in_s, tag_tail_s;

`ifdef IMEM_ARB_INIT_EN
   arb_state_e         state_r, state_nxt_s;
   logic [ADDRBIT-1:0] icnt_r, icnt_nxt_s;

   // FSM state and sweep counter
   always_ff @(posedge clk0 or negedge p0rst_) begin
      if (!p0rst_) begin
         state_r <= ST_INIT;
         icnt_r  <= {ADDRBIT{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         icnt_r  <= icnt_nxt_s;
      end
   end

   // terminal compare ends the sweep, so DEPTH = 2^ADDRBIT never wraps icnt
   always_comb begin
      state_nxt_s = state_r;
      icnt_nxt_s  = icnt_r;
      case (state_r)
         ST_INIT: begin
            if (icnt_r == LAST_ADDR) begin
               state_nxt_s = ST_RUN;
            end else begin
               icnt_nxt_s = icnt_r + ADDRBIT'(1'b1);
            end
         end
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = ST_INIT;
      endcase
   end

   assign init_act_s = (state_r == ST_INIT);
   assign init_a_s   = icnt_r;
   assign init_done  = (state_r == ST_RUN);
`else
   logic unused_cfg_s;

   assign unused_cfg_s = ^{FILL, LAST_ADDR};
   assign init_act_s   = 1'b0;
   assign init_a_s     = {ADDRBIT{1'b0}};
   assign init_done    = 1'b1;
`endif

   // arbitration and port-0 drive; address and write data hold when nothing is granted
   always_comb begin
      gnt0_s   = 1'b0;
      gnt1_s   = 1'b0;
      rr_nxt_s = rr_ptr_r;
      we_s     = 1'b0;
      re_s     = 1'b0;
      a_s      = mem_a_r;
      di_s     = mem_di_r;
      if (!p0rst_) begin
         rr_nxt_s = rr_ptr_r;
      end else if (init_act_s) begin
         we_s = 1'b1;
         a_s  = init_a_s;
         di_s = FILL;
      end else begin
         if (req0 && req1) begin
            gnt0_s   = (rr_ptr_r == 1'b0);
            gnt1_s   = (rr_ptr_r == 1'b1);
            rr_nxt_s = ~rr_ptr_r;
         end else begin
            gnt0_s = req0;
            gnt1_s = req1;
         end
         if (gnt0_s) begin
            a_s  = addr0;
            re_s = rnw0;
            we_s = ~rnw0;
            di_s = rnw0 ? mem_di_r : wdat0;
         end else if (gnt1_s) begin
            a_s  = addr1;
            re_s = rnw1;
            we_s = ~rnw1;
            di_s = rnw1 ? mem_di_r : wdat1;
         end else begin
            a_s = mem_a_r;
         end
      end
   end

   // round-robin pointer and held port-0 address/data
   always_ff @(posedge clk0 or negedge p0rst_) begin
      if (!p0rst_) begin
         rr_ptr_r <= 1'b0;
         mem_a_r  <= {ADDRBIT{1'b0}};
         mem_di_r <= {WIDTH{1'b0}};
      end else begin
         rr_ptr_r <= rr_nxt_s;
         mem_a_r  <= a_s;
         mem_di_r <= di_s;
      end
   end

   assign tag_in_s = '{vld: re_s, id: gnt1_s};

   imem_rd_tagpipe #(
      .RDLAT (RDLAT)
   ) u_tagpipe (
      .clk0    (clk0),
      .p0rst_  (p0rst_),
      .tag_in  (tag_in_s),
      .tag_out (tag_tail_s)
   );

   assign gnt0   = gnt0_s;
   assign gnt1   = gnt1_s;
   assign mem_a  = a_s;
   assign mem_we = we_s;
   assign mem_re = re_s;
   assign mem_di = di_s;
   assign rdvld0 = tag_tail_s.vld & (tag_tail_s.id == 1'b0);
   assign rdvld1 = tag_tail_s.vld & (tag_tail_s.id == 1'b1);
   assign rddat0 = tag_tail_s.vld ? mem_do : {WIDTH{1'b0}};
   assign rddat1 = tag_tail_s.vld ? mem_do : {WIDTH{1'b0}};

endmodule

// File: tb/tb_imem_port0_arb.sv
// Directed bench for imem_port0_arb with a 3-stage registered memory model on port 0.
module tb_imem_port0_arb;

   localparam int ADDRBIT = 6;
   localparam int DEPTH   = 48;
   localparam int WIDTH   = 80;
   localparam int RDLAT   = 3;
   localparam logic [WIDTH-1:0] ONE  = 80'd1;
   localparam logic [WIDTH-1:0] ZERO = 80'd0;

   logic               clk0 = 1'b0;
   logic               p0rst_ = 1'b0;
   logic               req0, rnw0, req1, rnw1;
   logic [ADDRBIT-1:0] addr0, addr1;
   logic [WIDTH-1:0]   wdat0, wdat1;
   logic               gnt0, gnt1, rdvld0, rdvld1, mem_we, mem_re, init_done;
   logic [WIDTH-1:0]   rddat0, rddat1, mem_di, mem_do;
   logic [ADDRBIT-1:0] mem_a;

   int vectors = 0;
   int miscompares = 0;

   logic [WIDTH-1:0]   ram [0:(1<<ADDRBIT)-1];
   logic               seeded = 1'b0;
   logic [ADDRBIT-1:0] a_p1;
   logic [WIDTH-1:0]   d_p2;

   imem_port0_arb #(
      .ADDRBIT (ADDRBIT), .DEPTH (DEPTH), .WIDTH (WIDTH), .RDLAT (RDLAT), .FILL (80'd0)
   ) dut (
      .clk0 (clk0), .p0rst_ (p0rst_),
      .req0 (req0), .rnw0 (rnw0), .addr0 (addr0), .wdat0 (wdat0),
      .req1 (req1), .rnw1 (rnw1), .addr1 (addr1), .wdat1 (wdat1),
      .gnt0 (gnt0), .gnt1 (gnt1), .rdvld0 (rdvld0), .rdvld1 (rdvld1),
      .rddat0 (rddat0), .rddat1 (rddat1),
      .mem_a (mem_a), .mem_we (mem_we), .mem_re (mem_re), .mem_di (mem_di), .mem_do (mem_do),
      .init_done (init_done)
   );

   always #5 clk0 = ~clk0;

   // wrapper model: input register, RAM, output register; pre-seeded so the init sweep is visible
   always @(posedge clk0) begin
      if (!seeded) begin
         for (int i = 0; i < (1 << ADDRBIT); i++) ram[i] <= 80'hDEAD;
         seeded <= 1'b1;
      end else if (mem_we) begin
         ram[mem_a] <= mem_di;
      end
      a_p1   <= mem_a;
      d_p2   <= ram[a_p1];
      mem_do <= d_p2;
   end

   task automatic check_vec(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk0);
      #1;
   endtask

   initial begin
      req0 = 1'b0; rnw0 = 1'b1; addr0 = '0; wdat0 = '0;
      req1 = 1'b0; rnw1 = 1'b1; addr1 = '0; wdat1 = '0;
      #2;
      check_vec("rst_gnt0", WIDTH'(gnt0), ZERO);
      check_vec("rst_gnt1", WIDTH'(gnt1), ZERO);
      check_vec("rst_rdvld", WIDTH'({rdvld1, rdvld0}), ZERO);
      check_vec("rst_rddat", rddat0, ZERO);
      check_vec("rst_mem_a", WIDTH'(mem_a), ZERO);
      check_vec("rst_we_re", WIDTH'({mem_we, mem_re}), ZERO);
      check_vec("rst_mem_di", mem_di, ZERO);
`ifdef IMEM_ARB_INIT_EN
      check_vec("rst_init_done", WIDTH'(init_done), ZERO);
`else
      check_vec("rst_init_done", WIDTH'(init_done), ONE);
`endif
      @(posedge clk0);
      next_cyc();
      p0rst_ = 1'b1;

`ifdef IMEM_ARB_INIT_EN
      // requester 0 waits through the sweep, then reads 0 and 47
      req0 = 1'b1; rnw0 = 1'b1; addr0 = 6'd0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk0);
         check_vec("init_we", WIDTH'(mem_we), ONE);
         check_vec("init_a", WIDTH'(mem_a), WIDTH'(i));
         check_vec("init_di", mem_di, ZERO);
         check_vec("init_gnt0", WIDTH'(gnt0), ZERO);
         check_vec("init_done_lo", WIDTH'(init_done), ZERO);
         next_cyc();
      end
      @(negedge clk0);
      check_vec("init_done_hi", WIDTH'(init_done), ONE);
      check_vec("first_gnt0", WIDTH'(gnt0), ONE);
      check_vec("first_re", WIDTH'(mem_re), ONE);
      check_vec("first_a", WIDTH'(mem_a), ZERO);
      next_cyc(); addr0 = 6'd47;
      @(negedge clk0);
      check_vec("rd47_gnt0", WIDTH'(gnt0), ONE);
      next_cyc(); req0 = 1'b0;
      @(negedge clk0);
      check_vec("fill_early", WIDTH'(rdvld0), ZERO);
      next_cyc();
      @(negedge clk0);
      check_vec("fill0_vld", WIDTH'(rdvld0), ONE);
      check_vec("fill0_dat", rddat0, ZERO);
      next_cyc();
      @(negedge clk0);
      check_vec("fill47_vld", WIDTH'(rdvld0), ONE);
      check_vec("fill47_dat", rddat0, ZERO);
      next_cyc();
`endif

      // write 0xA5 to 5 by requester 0, then read 5 by requester 1
      req0 = 1'b1; rnw0 = 1'b0; addr0 = 6'd5; wdat0 = 80'hA5;
      @(negedge clk0);
      check_vec("wr5_gnt0", WIDTH'(gnt0), ONE);
      check_vec("wr5_we", WIDTH'({mem_we, mem_re}), 80'd2);
      check_vec("wr5_a", WIDTH'(mem_a), 80'd5);
      check_vec("wr5_di", mem_di, 80'hA5);
      next_cyc(); req0 = 1'b0; req1 = 1'b1; rnw1 = 1'b1; addr1 = 6'd5;
      @(negedge clk0);
      check_vec("rd5_gnt", WIDTH'({gnt1, gnt0}), 80'd2);
      check_vec("rd5_re", WIDTH'({mem_we, mem_re}), 80'd1);
      check_vec("rd5_di_hold", mem_di, 80'hA5);
      next_cyc(); req1 = 1'b0;
      @(negedge clk0);
      check_vec("idle_a_hold", WIDTH'(mem_a), 80'd5);
      check_vec("idle_we_re", WIDTH'({mem_we, mem_re}), ZERO);
      check_vec("rd5_early1", WIDTH'(rdvld1), ZERO);
      next_cyc();
      @(negedge clk0);
      check_vec("rd5_early2", WIDTH'(rdvld1), ZERO);
      next_cyc();
      @(negedge clk0);
      check_vec("rd5_vld", WIDTH'({rdvld1, rdvld0}), 80'd2);
      check_vec("rd5_dat", rddat1, 80'hA5);
      next_cyc();

      // seed 3 and 4, then requester 1 reads them back to back
      req0 = 1'b1; rnw0 = 1'b0; addr0 = 6'd3; wdat0 = 80'h1111;
      next_cyc(); req0 = 1'b0; req1 = 1'b1; rnw1 = 1'b0; addr1 = 6'd4; wdat1 = 80'h2222;
      @(negedge clk0);
      check_vec("wr4_gnt1", WIDTH'(gnt1), ONE);
      next_cyc(); rnw1 = 1'b1; addr1 = 6'd3;
      next_cyc(); addr1 = 6'd4;
      @(negedge clk0);
      check_vec("b2b_a", WIDTH'(mem_a), 80'd4);
      next_cyc(); req1 = 1'b0;
      @(negedge clk0);
      check_vec("b2b_early", WIDTH'(rdvld1), ZERO);
      next_cyc();
      @(negedge clk0);
      check_vec("b2b_vld3", WIDTH'(rdvld1), ONE);
      check_vec("b2b_dat3", rddat1, 80'h1111);
      next_cyc();
      @(negedge clk0);
      check_vec("b2b_vld4", WIDTH'(rdvld1), ONE);
      check_vec("b2b_dat4", rddat1, 80'h2222);
      next_cyc();
      @(negedge clk0);
      check_vec("b2b_done", WIDTH'(rdvld1), ZERO);
      next_cyc();

      // both requesters read continuously: grants and returns alternate 0,1,0,1
      rnw0 = 1'b1; addr0 = 6'd3; rnw1 = 1'b1; addr1 = 6'd4;
      for (int k = 0; k < 8; k++) begin
         req0 = (k < 4); req1 = (k < 4);
         @(negedge clk0);
         if (k < 4) check_vec("alt_gnt", WIDTH'({gnt1, gnt0}), (k % 2 == 0) ? 80'd1 : 80'd2);
         if (k >= 3 && k <= 6) begin
            check_vec("alt_vld", WIDTH'({rdvld1, rdvld0}), ((k - 3) % 2 == 0) ? 80'd1 : 80'd2);
            check_vec("alt_dat", rddat0, ((k - 3) % 2 == 0) ? 80'h1111 : 80'h2222);
         end
         next_cyc();
      end

      // pointer moves only on contested grants
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk0); check_vec("rr_c1", WIDTH'({gnt1, gnt0}), 80'd1);
      next_cyc(); req1 = 1'b0;
      @(negedge clk0); check_vec("rr_solo0", WIDTH'({gnt1, gnt0}), 80'd1);
      next_cyc(); req1 = 1'b1;
      @(negedge clk0); check_vec("rr_c2", WIDTH'({gnt1, gnt0}), 80'd2);
      next_cyc();
      @(negedge clk0); check_vec("rr_c3", WIDTH'({gnt1, gnt0}), 80'd1);
      next_cyc(); req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 4; k++) next_cyc();

      // reset pulse with two reads in flight
      req0 = 1'b1; addr0 = 6'd3;
      @(negedge clk0); check_vec("prerst_gnt0", WIDTH'(gnt0), ONE);
      next_cyc(); req0 = 1'b0; req1 = 1'b1; addr1 = 6'd4;
      @(negedge clk0); check_vec("prerst_gnt1", WIDTH'(gnt1), ONE);
      next_cyc(); req1 = 1'b0; p0rst_ = 1'b0;
      @(negedge clk0);
      check_vec("midrst_vld", WIDTH'({rdvld1, rdvld0}), ZERO);
      check_vec("midrst_we_re", WIDTH'({mem_we, mem_re}), ZERO);
`ifdef IMEM_ARB_INIT_EN
      check_vec("midrst_done", WIDTH'(init_done), ZERO);
`else
      check_vec("midrst_done", WIDTH'(init_done), ONE);
`endif
      next_cyc(); p0rst_ = 1'b1;
`ifndef IMEM_ARB_INIT_EN
      req0 = 1'b1; addr0 = 6'd3;
`endif
      for (int k = 0; k < 4; k++) begin
         @(negedge clk0);
         check_vec("postrst_vld1", WIDTH'(rdvld1), ZERO);
`ifdef IMEM_ARB_INIT_EN
         check_vec("postrst_vld0", WIDTH'(rdvld0), ZERO);
         check_vec("resweep_we", WIDTH'(mem_we), ONE);
         check_vec("resweep_a", WIDTH'(mem_a), WIDTH'(k));
         check_vec("resweep_done", WIDTH'(init_done), ZERO);
`else
         if (k == 0) check_vec("postrst_gnt0", WIDTH'(gnt0), ONE);
         check_vec("postrst_vld0", WIDTH'(rdvld0), (k == 3) ? ONE : ZERO);
         if (k == 3) check_vec("postrst_dat", rddat0, 80'h1111);
`endif
         next_cyc();
         req0 = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
